// File: rtl/alu_pkg.sv
// Shared constants, opcode/state enums and shift-class helpers for the ALU execute stage.
package alu_pkg;

    localparam int N = 32;
    localparam int O = 3;
    localparam int S = 5;

    typedef enum logic [O-1:0] {
        OP_ADD  = 3'b000,
        OP_HADD = 3'b001,
        OP_SUB  = 3'b010,
        OP_NOT  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_LHG  = 3'b111
    } arith_op_e;

    typedef enum logic [O-1:0] {
        SH_SLL = 3'b000,
        SH_SLA = 3'b001,
        SH_SRL = 3'b010,
        SH_SRA = 3'b011
    } shift_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Every code outside the four named shifts behaves as a logical right shift.
    function automatic logic shift_is_left(input logic [O-1:0] op);
        return (op == SH_SLL) || (op == SH_SLA);
    endfunction

    function automatic logic shift_is_arith(input logic [O-1:0] op);
        return op == SH_SRA;
    endfunction

endpackage

// File: rtl/alu_execute_if.sv
// Preprocessor-to-execute operand bus; busy flows back to the preprocessor.
interface alu_execute_if;
    import alu_pkg::*;

    logic         enable_ex;
    logic [N-1:0] aluin1;
    logic [N-1:0] aluin2;
    logic [O-1:0] operation_out;
    logic [S-1:0] shift_number;
    logic         enable_arith;
    logic         enable_shift;
    logic         busy;

    modport master (
        output enable_ex, aluin1, aluin2, operation_out, shift_number,
               enable_arith, enable_shift,
        input  busy
    );

    modport slave (
        input  enable_ex, aluin1, aluin2, operation_out, shift_number,
               enable_arith, enable_shift,
        output busy
    );

endinterface

// File: rtl/alu_shifter.sv
// Shift unit: iterative one-bit-per-cycle FSM by default, single-cycle barrel
// shifter when ALU_EXEC_FAST_SHIFT_EN is defined. done marks the cycle res/cout are final.
module alu_shifter
    import alu_pkg::*;
(
`ifndef ALU_EXEC_FAST_SHIFT_EN
    input  logic         clock,
    input  logic         reset,
`endif
    input  logic         start,
    input  logic [O-1:0] op,
    input  logic [S-1:0] amt,
    input  logic [N-1:0] operand,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res,
    output logic         cout
);

`ifdef ALU_EXEC_FAST_SHIFT_EN

    logic [N:0] left_ext;
    logic [N:0] right_ext;

    // The extra guard bit catches the last bit shifted out; it stays 0 for amt=0.
    always_comb begin
        left_ext = {1'b0, operand} << amt;
        if (shift_is_arith(op)) begin
            right_ext = $unsigned($signed({operand, 1'b0}) >>> amt);
        end else begin
            right_ext = {operand, 1'b0} >> amt;
        end
        if (shift_is_left(op)) begin
            res  = left_ext[N-1:0];
            cout = left_ext[N];
        end else begin
            res  = right_ext[N:1];
            cout = right_ext[0];
        end
    end

    assign busy = 1'b0;
    assign done = start;

`else

    state_e       state_q;
    state_e       state_d;
    logic [S-1:0] count_q;
    logic [S-1:0] count_d;
    logic [N-1:0] work_q;
    logic [O-1:0] op_q;
    logic [N-1:0] step_res;
    logic         step_out;

    always_comb begin
        if (shift_is_left(op_q)) begin
            step_res = {work_q[N-2:0], 1'b0};
            step_out = work_q[N-1];
        end else begin
            step_res = {shift_is_arith(op_q) & work_q[N-1], work_q[N-1:1]};
            step_out = work_q[0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (amt != '0)) begin
                    state_d = ST_SHIFT;
                    count_d = amt;
                end
            end
            ST_SHIFT: begin
                count_d = count_q - 1'b1;
                if (count_q == S'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // A zero-length shift finishes straight from IDLE with the operand untouched.
    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = 1'b0;
        res  = operand;
        cout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                done = start && (amt == '0);
            end
            ST_SHIFT: begin
                done = (count_q == S'(1));
                res  = step_res;
                cout = step_out;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if ((state_q == ST_IDLE) && start) begin
            work_q <= operand;
            op_q   <= op;
        end else if (state_q == ST_SHIFT) begin
            work_q <= step_res;
        end
    end

`endif

endmodule

// File: rtl/alu_execute.sv
// ALU execute stage: single-cycle arithmetic/logic, shifts via alu_shifter, registered results.
// Build option: ALU_EXEC_FAST_SHIFT_EN selects the single-cycle barrel shifter.
module alu_execute
    import alu_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    alu_execute_if.slave  bus,
    output logic [N-1:0]  aluout,
    output logic          carry,
    output logic          valid_out
);

    logic         sh_busy;
    logic         sh_done;
    logic [N-1:0] sh_res;
    logic         sh_cout;
    logic         accept_p0;
    logic         arith_go_p0;
    logic         shift_go_p0;
    logic [N:0]   arith_res_p0;
    logic [N-1:0] aluout_p1;
    logic         carry_p1;
    logic         vld_p1;

    // Result is {carry, value}; SUB carry is the unsigned borrow.
    function automatic logic [N:0] arith_eval(input logic [O-1:0]  op,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic [N:0]         r;
        logic [16:0]        h;
        logic signed [15:0] hs;
        h  = {1'b0, a[15:0]} + {1'b0, b[15:0]};
        hs = signed'(h[15:0]);
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_HADD: r = {h[16], N'(hs)};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_NOT:  r = {1'b0, ~b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_LHG:  r = {1'b0, b[15:0], 16'h0000};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Stage p0: accept and class priority
    assign accept_p0    = bus.enable_ex && !sh_busy;
    assign arith_go_p0  = accept_p0 && bus.enable_arith;
    assign shift_go_p0  = accept_p0 && !bus.enable_arith && bus.enable_shift;
    assign arith_res_p0 = arith_eval(bus.operation_out, bus.aluin1, bus.aluin2);
    assign bus.busy     = sh_busy;

    alu_shifter u_shifter (
`ifndef ALU_EXEC_FAST_SHIFT_EN
        .clock   (clock),
        .reset   (reset),
`endif
        .start   (shift_go_p0),
        .op      (bus.operation_out),
        .amt     (bus.shift_number),
        .operand (bus.aluin1),
        .busy    (sh_busy),
        .done    (sh_done),
        .res     (sh_res),
        .cout    (sh_cout)
    );

    // Stage p1: output registers, held until the next result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout_p1 <= '0;
            carry_p1  <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= arith_go_p0 || sh_done;
            if (arith_go_p0) begin
                {carry_p1, aluout_p1} <= arith_res_p0;
            end else if (sh_done) begin
                aluout_p1 <= sh_res;
                carry_p1  <= sh_cout;
            end
        end
    end

    assign aluout    = aluout_p1;
    assign carry     = carry_p1;
    assign valid_out = vld_p1;

endmodule

// File: tb/tb_alu_execute.sv
// Scoreboard bench for alu_execute: directed vectors queue expected results, a monitor checks them.
module tb_alu_execute;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] aluout;
    logic        carry;
    logic        valid_out;

    alu_execute_if bus();

    alu_execute dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .aluout    (aluout),
        .carry     (carry),
        .valid_out (valid_out)
    );

    always #5 clock = ~clock;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    exp_t mon_e;
    always @(negedge clock) begin
        if (reset && valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid_out=1 aluout=0x%08h expected no valid_out", aluout);
            end else begin
                mon_e = sb.pop_front();
                check1({mon_e.name, "_res"}, aluout, mon_e.res);
                check1({mon_e.name, "_carry"}, {31'b0, carry}, {31'b0, mon_e.c});
                check1({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    task automatic set_in(input bit en, input bit ar, input bit sh, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] n);
        bus.enable_ex     = en;
        bus.enable_arith  = ar;
        bus.enable_shift  = sh;
        bus.operation_out = op;
        bus.aluin1        = a;
        bus.aluin2        = b;
        bus.shift_number  = n;
    endtask

    task automatic wait_idle(output int bc);
        bc = 0;
        while (bus.busy === 1'b1 && bc < 200) begin
            @(posedge clock);
            #1;
            bc++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: got busy=%b after %0d cycles expected 0", bus.busy, bc);
        end
    endtask

    task automatic push_exp(input string nm, input logic [31:0] er, input logic ec, input int lat);
        exp_t e;
        e.res  = er;
        e.c    = ec;
        e.due  = cyc + lat;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input string nm, input bit ar, input bit sh, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] n,
                         input logic [31:0] er, input logic ec, output int bc);
        int lat;
        set_in(1'b1, ar, sh, op, a, b, n);
        @(posedge clock);
        #1;
        bus.enable_ex = 1'b0;
        lat = (ar || FAST || n == 5'd0) ? 0 : int'(n);
        if (ar || sh) push_exp(nm, er, ec, lat);
        wait_idle(bc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        int busy_total;
        set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (3) @(posedge clock);
        #1;
        check1("rst_aluout", aluout, 32'h0);
        check1("rst_carry", {31'b0, carry}, 32'h0);
        check1("rst_valid", {31'b0, valid_out}, 32'h0);
        check1("rst_busy", {31'b0, bus.busy}, 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Arithmetic/logic, issued back to back.
        issue("add_ovf",  1, 0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, bc);
        issue("add",      1, 0, 3'b000, 32'h1234_5678, 32'h1111_1111, 5'd0, 32'h2345_6789, 1'b0, bc);
        issue("hadd_sx",  1, 0, 3'b001, 32'h0000_7FFF, 32'h0000_0001, 5'd0, 32'hFFFF_8000, 1'b0, bc);
        issue("hadd_cy",  1, 0, 3'b001, 32'hAAAA_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0001, 1'b1, bc);
        issue("sub_brw",  1, 0, 3'b010, 32'h0000_0005, 32'h0000_0007, 5'd0, 32'hFFFF_FFFE, 1'b1, bc);
        issue("sub",      1, 0, 3'b010, 32'h0000_0007, 32'h0000_0005, 5'd0, 32'h0000_0002, 1'b0, bc);
        issue("not",      1, 0, 3'b011, 32'hFFFF_FFFF, 32'h0F0F_0000, 5'd0, 32'hF0F0_FFFF, 1'b0, bc);
        issue("and",      1, 0, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, bc);
        issue("or",       1, 0, 3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, bc);
        issue("xor",      1, 0, 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0, bc);
        issue("lhg",      1, 0, 3'b111, 32'h1234_5678, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1'b0, bc);

        // No-op: neither class enabled, outputs must hold.
        set_in(1'b1, 1'b0, 1'b0, 3'b000, 32'h5, 32'h6, 5'd0);
        @(posedge clock);
        #1;
        bus.enable_ex = 1'b0;
        @(posedge clock);
        #1;
        check1("noop_hold", aluout, 32'hABCD_0000);

        // Arith wins over shift when both class bits are set.
        issue("prio", 1, 1, 3'b000, 32'h0000_0001, 32'h0000_0002, 5'd3, 32'h0000_0003, 1'b0, bc);
        check1("prio_nobusy", 32'(bc), 32'd0);

        // SRA by 4 with an ignored ADD strobe (and changed operands) while busy.
        set_in(1'b1, 1'b0, 1'b1, 3'b011, 32'h8000_0001, 32'h0, 5'd4);
        @(posedge clock);
        #1;
        bus.enable_ex = 1'b0;
        push_exp("sra4", 32'hF800_0000, 1'b0, FAST ? 0 : 4);
        busy_total = 0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        check1("sra_busy_hi", {31'b0, bus.busy}, 32'h1);
        set_in(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'h0000_0001, 5'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        bus.enable_ex = 1'b0;
        busy_total = 2;
`endif
        wait_idle(bc);
        busy_total += bc;
        check1("sra_busy_cycles", 32'(busy_total), FAST ? 32'd0 : 32'd4);
        issue("add_after", 1, 0, 3'b000, 32'h0000_0010, 32'h0000_0020, 5'd0, 32'h0000_0030, 1'b0, bc);

        // Further shifts.
        issue("sll1",    0, 1, 3'b000, 32'h8000_0000, 32'h0, 5'd1, 32'h0000_0000, 1'b1, bc);
        issue("sll0",    0, 1, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 32'h1234_5678, 1'b0, bc);
        check1("sll0_nobusy", 32'(bc), 32'd0);
        issue("srl5",    0, 1, 3'b010, 32'h0000_00F0, 32'h0, 5'd5, 32'h0000_0007, 1'b1, bc);
        issue("op1xx",   0, 1, 3'b100, 32'h8000_0003, 32'h0, 5'd2, 32'h2000_0000, 1'b1, bc);
        issue("sla3",    0, 1, 3'b001, 32'h2000_0001, 32'h0, 5'd3, 32'h0000_0008, 1'b1, bc);
        issue("sra31",   0, 1, 3'b011, 32'h8000_0000, 32'h0, 5'd31, 32'hFFFF_FFFF, 1'b0, bc);

        // Reset during a shift with three steps remaining.
`ifdef ALU_EXEC_FAST_SHIFT_EN
        issue("sll5", 0, 1, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd5, 32'hFFFF_FFE0, 1'b1, bc);
`else
        set_in(1'b1, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd5);
        @(posedge clock);
        #1;
        bus.enable_ex = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check1("abort_busy_hi", {31'b0, bus.busy}, 32'h1);
`endif
        #2;
        reset = 1'b0;
        #1;
        check1("abort_aluout", aluout, 32'h0);
        check1("abort_carry", {31'b0, carry}, 32'h0);
        check1("abort_valid", {31'b0, valid_out}, 32'h0);
        check1("abort_busy", {31'b0, bus.busy}, 32'h0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        check1("abort_hold", aluout, 32'h0);
        issue("add_post", 1, 0, 3'b000, 32'h0000_0100, 32'h0000_0023, 5'd0, 32'h0000_0123, 1'b0, bc);
        issue("srl_post", 0, 1, 3'b010, 32'h0000_0123, 32'h0, 5'd3, 32'h0000_0024, 1'b0, bc);

        repeat (4) begin
            @(posedge clock);
            #1;
        end
        check1("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_execute.md
# alu_execute

Execution stage fed by the ALU preprocessor: consumes registered operands `aluin1`/`aluin2`, `operation_out`, `shift_number`, `enable_arith` and `enable_shift`, and produces the 32-bit `aluout` and `carry`. Arithmetic/logic ops complete in one cycle; shifts run through an iterative shifter FSM with a `busy` back-pressure signal. Sits between the preprocessor and writeback, and is the consuming end of the preprocessor output bus.

## Interface
- `N`, 32, datapath width
- `O`, 3, operation field width
- `S`, 5, shift amount width
- `clock`  input  1  single clock; all state updates on posedge
- `reset`  input  1  asynchronous, active-low; clears all state immediately
- `enable_ex`  input  1  op strobe; accepted only when `busy`=0
- `aluin1`, `aluin2`  input  N  operands
- `operation_out`  input  O  op code within class
- `shift_number`  input  S  shift amount, 0..31
- `enable_arith`  input  1  arithmetic/logic class
- `enable_shift`  input  1  shift class
- `aluout`  output  N  result, held until next result
- `carry`  output  1  carry/borrow/shifted-out bit
- `valid_out`  output  1  one-cycle pulse: new `aluout`/`carry` this cycle
- `busy`  output  1  shift in progress; upstream holds inputs

## Operation
- Accept: posedge with `enable_ex`=1, `busy`=0. `enable_arith`=1 takes priority over `enable_shift`. Both 0 is a no-op: no `valid_out`, outputs unchanged.
- Arith ops (`operation_out`):
  - 000 ADD: {carry,aluout}=aluin1+aluin2, 33-bit
  - 001 HADD: aluout=sext(aluin1[15:0]+aluin2[15:0]) from bit 15; carry=bit 16
  - 010 SUB: aluout=aluin1-aluin2 mod 2^32; carry=1 iff aluin1<aluin2 unsigned (borrow)
  - 011 NOT: ~aluin2
  - 100 AND, 101 OR, 110 XOR
  - 111 LHG: {aluin2[15:0],16'h0}
  - Logic ops and LHG: carry=0
- Shift ops, operand `aluin1`:
  - 000 SLL, 001 SLA (same as SLL), 010 SRL, 011 SRA (sign fill)
  - 1xx: treated as SRL
  - carry = last bit shifted out; 0 when `shift_number`=0
- FSM states IDLE and SHIFT:
  - IDLE→SHIFT on accepted shift with `shift_number`≠0: load work reg, count=`shift_number`.
  - SHIFT: one bit per edge, count decrements. On the edge where count goes 1→0, write `aluout`/`carry`, pulse `valid_out`, return to IDLE.
  - Accepted shift with `shift_number`=0 stays in IDLE and completes like an arith op.
- `busy`=1 exactly while in SHIFT. `enable_ex` during SHIFT is ignored; inputs are not sampled.

## Timing
- Reset values: `aluout`=0, `carry`=0, `valid_out`=0, `busy`=0, state IDLE, count 0.
- Arith latency: accepted at edge k → `valid_out`=1 and result visible after edge k+1... precisely, registered at edge k; valid during cycle k→k+1.
- Iterative shift latency: accept at edge k; `busy` high cycles k..k+n-1; result and `valid_out` registered at edge k+n, where n=`shift_number`.
- Back-to-back arith: one result per cycle, `valid_out` continuously high.
- A new op is accepted on the first edge after `busy` falls.
- Reset asserted mid-shift aborts the shift: no `valid_out`, outputs return to reset values.

## Configuration
- `ALU_EXEC_FAST_SHIFT_EN` defined: barrel shifter is used, all shifts complete with arith latency (1 cycle), `busy` is tied 0, and SHIFT state is absent.
- Not defined: iterative shifter as described above.
- Results and carry are bit-identical in both builds.

## Structure
- Shared package `alu_pkg`: `N`/`O`/`S` constants, arith opcode enum, shift opcode enum, FSM state enum.
- Sub-module `alu_shifter`: work register, count and carry-out; contains the iterative or barrel variant selected by the macro.
- The top level holds arith logic, class priority and output registers.

## Test plan
- ADD 0xFFFF_FFFF + 0x1 → aluout 0x0, carry 1, valid_out one cycle after accept.
- SUB 0x5 − 0x7 → aluout 0xFFFF_FFFE, carry 1; LHG aluin2=0x0000_ABCD → 0xABCD_0000, carry 0.
- SRA aluin1=0x8000_0001, shift_number 4 → busy for 4 cycles, then aluout 0xF800_0000, carry 0; with macro: 1-cycle latency, same result.
- SLL 0x8000_0000 by 1 → aluout 0x0, carry 1; shift_number 0 → aluout unchanged operand, carry 0, 1-cycle latency.
- enable_ex pulsed with new ADD while busy → ignored; ADD applied after busy drops gives exactly one valid_out per accepted op.
- Reset asserted during SHIFT with count 3 → outputs 0 immediately, no valid_out; next op after release behaves normally.
